// File: rtl/audio_out_buffer.sv
// -----------------------------------------------------------------------------
// audio_out_buffer
//
// Receives 11-bit audio samples from the processor datapath over a 4-phase
// flag handshake (sample_valid = datapath R14, sample_ack = datapath R13).
// Samples are queued in a small FIFO and played back one per SAMPLE_DIV
// clocks as a PWM bit stream. Playback starts once PREFILL samples are
// queued. After the program signals finish, the FIFO is drained and the
// block parks in DONE with the output at mid-scale.
//
// Ports
//   clkFPGA       in   1   single clock, rising edge
//   rst           in   1   asynchronous active-low reset
//   sample_in     in  11   unsigned sample (datapath R6_audio)
//   sample_valid  in   1   sample request (datapath R14_flag)
//   finish        in   1   end of program (datapath finish)
//   sample_ack    out  1   handshake acknowledge (datapath R13_flag)
//   pwm_out       out  1   PWM audio bit, registered
//   dac_sample    out 11   sample currently being played
//   underrun      out  1   sticky: a playback slot found the FIFO empty
//   done          out  1   high once the program's audio has fully drained
// -----------------------------------------------------------------------------
module audio_out_buffer #(
    parameter int DEPTH      = 16,
    parameter int SAMPLE_DIV = 1134,
    parameter int PREFILL    = 8
) (
    input  logic        clkFPGA,
    input  logic        rst,
    input  logic [10:0] sample_in,
    input  logic        sample_valid,
    input  logic        finish,
    output logic        sample_ack,
    output logic        pwm_out,
    output logic [10:0] dac_sample,
    output logic        underrun,
    output logic        done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
    localparam logic [CW-1:0] PREFILL_CNT = CW'(PREFILL);
    localparam logic [TW-1:0] TICK_LAST   = TW'(SAMPLE_DIV - 1);
    localparam logic [10:0]   MID_SCALE   = 11'd1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_PLAY    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic          r_vs_meta;
    logic          r_vs;
    logic          r_fs_meta;
    logic          r_fs;
    logic          r_ack;

    logic [10:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    logic [TW-1:0] r_tick_cnt;
    logic [10:0]   r_p;
    logic          r_pwm;
    logic [10:0]   r_dac;
    logic          r_underrun;
    logic          r_done;

    logic          w_tick;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_starve;
    logic          w_drain_end;

    assign w_tick  = (r_tick_cnt == TICK_LAST);
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == {CW{1'b0}});

    // A push needs a fresh request (ack still low), room in the FIFO, and a
    // program that has not already finished playing out.
    assign w_push = r_vs & ~r_ack & ~w_full & (r_state != ST_DONE);

    // Playback slots: pop when data is available, otherwise either flag a
    // starved slot (PLAY) or conclude the drain (DRAIN).
    assign w_pop       = w_tick & ~w_empty & ((r_state == ST_PLAY) | (r_state == ST_DRAIN));
    assign w_starve    = w_tick & w_empty & (r_state == ST_PLAY);
    assign w_drain_end = w_tick & w_empty & (r_state == ST_DRAIN);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CW'(1);
        end else begin
            w_count_next = r_count;
        end
    end

    // Next-state logic for the playback controller.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_next_state = ST_PREFILL;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_PREFILL: begin
                // A program can finish before it ever reaches the prefill level.
                if (r_fs) begin
                    w_next_state = ST_DRAIN;
                end else if (w_count_next >= PREFILL_CNT) begin
                    w_next_state = ST_PLAY;
                end else begin
                    w_next_state = ST_PREFILL;
                end
            end
            ST_PLAY: begin
                if (r_fs) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_PLAY;
                end
            end
            ST_DRAIN: begin
                if (w_drain_end) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_next_state = ST_DONE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Two-flop synchronizers for the datapath flags.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            r_vs_meta <= 1'b0;
            r_vs      <= 1'b0;
            r_fs_meta <= 1'b0;
            r_fs      <= 1'b0;
        end else begin
            r_vs_meta <= sample_valid;
            r_vs      <= r_vs_meta;
            r_fs_meta <= finish;
            r_fs      <= r_fs_meta;
        end
    end

    // Acknowledge: set by the push, held until the request drops.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            r_ack <= 1'b0;
        end else if (w_push) begin
            r_ack <= 1'b1;
        end else if (!r_vs) begin
            r_ack <= 1'b0;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
        end
    end

    // FIFO storage; contents are meaningless after reset since pointers clear.
    always_ff @(posedge clkFPGA) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    // Sample-rate divider, free-running in every state.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= {TW{1'b0}};
        end else if (w_tick) begin
            r_tick_cnt <= {TW{1'b0}};
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Current sample, sticky underrun and done flag.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            r_dac      <= MID_SCALE;
            r_underrun <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_dac <= r_mem[r_rd_ptr];
            end else if (w_drain_end) begin
                r_dac <= MID_SCALE;
            end
            if (w_starve) begin
                r_underrun <= 1'b1;
            end
            r_done <= (w_next_state == ST_DONE);
        end
    end

    // PWM ramp and comparator; the ramp wraps naturally at 2048.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            r_p   <= 11'd0;
            r_pwm <= 1'b0;
        end else begin
            r_p   <= r_p + 11'd1;
            r_pwm <= (r_p < r_dac);
        end
    end

    assign sample_ack = r_ack;
    assign pwm_out    = r_pwm;
    assign dac_sample = r_dac;
    assign underrun   = r_underrun;
    assign done       = r_done;

endmodule

// File: tb/tb_audio_out_buffer.sv
// -----------------------------------------------------------------------------
// tb_audio_out_buffer
//
// Directed scenarios (prefill, underrun, async reset, full stall, drain/done,
// PWM duty) followed by a randomized push/finish run. Every cycle the DUT
// outputs are compared with a queue-based reference model of the buffer.
// -----------------------------------------------------------------------------
module tb_audio_out_buffer;

    localparam int DEPTH = 4;
    localparam int DIV   = 32;
    localparam int PRE   = 4;

    localparam int M_IDLE = 0, M_PREFILL = 1, M_PLAY = 2, M_DRAIN = 3, M_DONE = 4;

    logic        clk;
    logic        rst;
    logic [10:0] sample_in;
    logic        sample_valid;
    logic        finish;
    logic        sample_ack;
    logic        pwm_out;
    logic [10:0] dac_sample;
    logic        underrun;
    logic        done;

    audio_out_buffer #(
        .DEPTH(DEPTH),
        .SAMPLE_DIV(DIV),
        .PREFILL(PRE)
    ) dut (
        .clkFPGA(clk),
        .rst(rst),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .finish(finish),
        .sample_ack(sample_ack),
        .pwm_out(pwm_out),
        .dac_sample(dac_sample),
        .underrun(underrun),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [10:0] m_fifo[$];
    int          m_n;
    int          m_mode;
    logic        m_vs1, m_vs2, m_fs1, m_fs2;
    logic        m_ack, m_pwm, m_underrun, m_done;
    logic [10:0] m_dac;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_n = 0; m_mode = M_IDLE;
        m_vs1 = 1'b0; m_vs2 = 1'b0; m_fs1 = 1'b0; m_fs2 = 1'b0;
        m_ack = 1'b0; m_pwm = 1'b0; m_underrun = 1'b0; m_done = 1'b0;
        m_dac = 11'd1024;
    endtask

    // One clock edge of the buffer's behaviour, evaluated from pre-edge values.
    task automatic model_step();
        bit tick, push, pop;
        int size0;
        if (rst !== 1'b1) begin
            model_reset();
            return;
        end
        tick  = ((m_n % DIV) == DIV - 1);
        size0 = m_fifo.size();
        push  = m_vs2 && !m_ack && (size0 < DEPTH) && (m_mode != M_DONE);
        pop   = tick && (size0 > 0) && (m_mode == M_PLAY || m_mode == M_DRAIN);
        m_pwm = ((m_n % 2048) < int'(m_dac));
        if (pop) m_dac = m_fifo.pop_front();
        if (tick && size0 == 0 && m_mode == M_PLAY) m_underrun = 1'b1;
        if (push) m_fifo.push_back(sample_in);
        if (push) m_ack = 1'b1;
        else if (!m_vs2) m_ack = 1'b0;
        case (m_mode)
            M_IDLE:    if (push) m_mode = M_PREFILL;
            M_PREFILL: if (m_fs2) m_mode = M_DRAIN;
                       else if (m_fifo.size() >= PRE) m_mode = M_PLAY;
            M_PLAY:    if (m_fs2) m_mode = M_DRAIN;
            M_DRAIN:   if (tick && size0 == 0) begin
                           m_mode = M_DONE;
                           m_dac  = 11'd1024;
                       end
            default:   ;
        endcase
        m_done = (m_mode == M_DONE);
        m_vs2 = m_vs1; m_vs1 = sample_valid;
        m_fs2 = m_fs1; m_fs1 = finish;
        m_n++;
    endtask

    task automatic check_outputs();
        chk("sample_ack", sample_ack, m_ack);
        chk("dac_sample", dac_sample, m_dac);
        chk("pwm_out",    pwm_out,    m_pwm);
        chk("underrun",   underrun,   m_underrun);
        chk("done",       done,       m_done);
    endtask

    // Advance one clock (called and returning at a falling edge).
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        sample_valid = 1'b0;
        finish       = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_ack",      sample_ack, 0);
        chk("rst_dac",      dac_sample, 1024);
        chk("rst_underrun", underrun,   0);
        chk("rst_done",     done,       0);
        chk("rst_pwm",      pwm_out,    0);
        model_reset();
        @(negedge clk);
        cyc();
        rst = 1'b1;
    endtask

    task automatic push_sample(input logic [10:0] v, input int hold);
        int k;
        sample_in    = v;
        sample_valid = 1'b1;
        k = 0;
        while (sample_ack !== 1'b1 && k < 8 * DIV) begin cyc(); k++; end
        chk("ack_rise", sample_ack, 1);
        for (int i = 0; i < hold; i++) cyc();
        sample_valid = 1'b0;
        k = 0;
        while (sample_ack !== 1'b0 && k < 16) begin cyc(); k++; end
        chk("ack_fall", sample_ack, 0);
    endtask

    task automatic wait_dac_change(input logic [10:0] prev, output int k);
        k = 0;
        while (dac_sample === prev && k < 4 * DIV) begin cyc(); k++; end
        chk("dac_change_seen", (dac_sample !== prev), 1);
    endtask

    task automatic wait_underrun(output int k);
        k = 0;
        while (underrun !== 1'b1 && k < 8 * DIV) begin cyc(); k++; end
        chk("underrun_seen", underrun, 1);
    endtask

    task automatic count_pwm_high(output int highs);
        highs = 0;
        for (int i = 0; i < 2048; i++) begin
            cyc();
            if (pwm_out === 1'b1) highs++;
        end
    endtask

    initial begin
        int k, pop_k, highs, acks;
        rst = 1'b0; sample_valid = 1'b0; finish = 1'b0; sample_in = 11'd0;
        model_reset();
        @(negedge clk);
        chk("init_ack", sample_ack, 0);
        chk("init_dac", dac_sample, 1024);
        chk("init_done", done, 0);
        cyc();
        rst = 1'b1;

        // Prefill: nothing plays until the fourth sample is in
        push_sample(11'd100, 0);
        push_sample(11'd200, 2);
        push_sample(11'd300, 0);
        push_sample(11'd400, 0);
        chk("prefill_no_pop", dac_sample, 1024);
        wait_dac_change(11'd1024, k);
        chk("first_pop", dac_sample, 100);
        wait_dac_change(11'd100, k);
        chk("pop_200", dac_sample, 200);
        chk("pop_interval", k, DIV);
        wait_dac_change(11'd200, k);
        chk("pop_300", dac_sample, 300);
        chk("pop_interval", k, DIV);
        wait_dac_change(11'd300, k);
        chk("pop_400", dac_sample, 400);

        // Underrun: next slot finds the FIFO empty
        wait_underrun(k);
        chk("underrun_slot", k, DIV);
        chk("underrun_hold", dac_sample, 400);
        push_sample(11'd7, 0);
        chk("underrun_sticky", underrun, 1);

        // Reset while playing
        do_reset();

        // Full stall: fifth request waits for the first pop
        push_sample(11'd11, 0);
        push_sample(11'd22, 0);
        push_sample(11'd33, 0);
        push_sample(11'd44, 0);
        sample_in = 11'd55; sample_valid = 1'b1;
        k = 0; pop_k = -1;
        while (sample_ack !== 1'b1 && k < 8 * DIV) begin
            cyc(); k++;
            if (pop_k < 0 && dac_sample !== 11'd1024) pop_k = k;
        end
        chk("stall_ack", sample_ack, 1);
        chk("stall_ack_after_pop", k - pop_k, 1);
        chk("stall_first", dac_sample, 11);
        sample_valid = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        wait_dac_change(11'd11, k);
        chk("order_22", dac_sample, 22);

        // Drain with three entries queued
        finish = 1'b1;
        wait_dac_change(11'd22, k);
        chk("drain_33", dac_sample, 33);
        wait_dac_change(11'd33, k);
        chk("drain_44", dac_sample, 44);
        wait_dac_change(11'd44, k);
        chk("drain_55", dac_sample, 55);
        k = 0;
        while (done !== 1'b1 && k < 4 * DIV) begin cyc(); k++; end
        chk("done_rise", done, 1);
        chk("done_slot", k, DIV);
        chk("done_dac", dac_sample, 1024);
        chk("done_underrun", underrun, 0);
        sample_in = 11'd99; sample_valid = 1'b1;
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (sample_ack === 1'b1) acks++;
        end
        chk("done_no_ack", acks, 0);
        sample_valid = 1'b0;
        cyc();

        // Randomized pushes then finish
        do_reset();
        for (int i = 0; i < 24; i++) begin
            int gap;
            gap = int'($urandom_range(0, 20));
            for (int g = 0; g < gap; g++) cyc();
            push_sample(11'($urandom_range(0, 2047)), int'($urandom_range(0, 4)));
        end
        finish = 1'b1;
        k = 0;
        while (done !== 1'b1 && k < 20 * DIV) begin cyc(); k++; end
        chk("rand_done", done, 1);
        cyc();

        // PWM duty at 512
        do_reset();
        push_sample(11'd900, 0);
        push_sample(11'd30, 0);
        push_sample(11'd1500, 0);
        push_sample(11'd512, 0);
        wait_underrun(k);
        chk("duty_dac", dac_sample, 512);
        count_pwm_high(highs);
        chk("duty_512", highs, 512);

        // PWM at zero
        do_reset();
        push_sample(11'd10, 0);
        push_sample(11'd20, 0);
        push_sample(11'd30, 0);
        push_sample(11'd0, 0);
        wait_underrun(k);
        chk("zero_dac", dac_sample, 0);
        count_pwm_high(highs);
        chk("duty_0", highs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_out_buffer.md
# audio_out_buffer

Downstream consumer of the processor datapath's audio outputs. Accepts 11-bit samples that the program places in R6 under a flag handshake: the program raises R14 and the block acknowledges on R13. Samples are buffered in a FIFO and played back at a fixed sample rate as a PWM bit stream, with prefill, drain-on-finish and underrun handling. The block sits between the datapath outputs (R6_audio, R14_flag, finish) and the board audio pin, and drives the datapath's R13_flag input.

## Interface
- DEPTH, 16 — FIFO entries; power of two, ≥4.
- SAMPLE_DIV, 1134 — clkFPGA cycles per output sample (50 MHz / 44.1 kHz).
- PREFILL, 8 — FIFO occupancy required before playback starts; 1 ≤ PREFILL ≤ DEPTH.
- clkFPGA  in  1  — single clock; all state is on its rising edge.
- rst  in  1  — asynchronous, active-low reset.
- sample_in  in  11  — unsigned sample; connects to datapath R6_audio.
- sample_valid  in  1  — program request; connects to datapath R14_flag.
- finish  in  1  — end of program; connects to datapath finish.
- sample_ack  out  1  — acknowledge; connects to datapath R13_flag.
- pwm_out  out  1  — PWM audio bit.
- dac_sample  out  11  — sample currently being played.
- underrun  out  1  — sticky; set on a pop from an empty FIFO during PLAY.
- done  out  1  — high in DONE.

## Operation
- **Input sync:** sample_valid and finish each pass through a 2-flop synchronizer (vs, fs).
- **Handshake, 4-phase:**
  - Push when vs=1, sample_ack=0 and the FIFO is not full. The push writes sample_in and sets sample_ack.
  - sample_ack stays high while vs=1 and clears the cycle after vs=0.
  - If the FIFO is full, sample_ack stays low and the push waits until space frees.
  - A held-high sample_valid never produces a second push.
- **FIFO:**
  - Uses log2(DEPTH)-bit read/write pointers that wrap, plus an occupancy count of width log2(DEPTH)+1.
  - full = (count == DEPTH); empty = (count == 0).
  - A simultaneous push and pop leaves count unchanged; both pointers advance.
- **Tick counter:**
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick is high for one cycle when the counter equals SAMPLE_DIV-1.
  - The counter runs in every state; it is cleared only by reset.
- **State machine** (states IDLE, PREFILL, PLAY, DRAIN, DONE):
  - IDLE → PREFILL on the first push.
  - PREFILL → PLAY when count ≥ PREFILL (evaluated after that cycle's push).
  - PREFILL → DRAIN when fs=1 (short programs).
  - PLAY → DRAIN when fs=1.
  - DRAIN → DONE on a tick with count == 0.
  - DONE is terminal until reset.
- **Pop rules:**
  - PLAY or DRAIN, tick, FIFO non-empty: pop into dac_sample.
  - PLAY, tick, FIFO empty: dac_sample holds its value and underrun sets.
  - DRAIN, tick, FIFO empty: no underrun; go to DONE and load dac_sample = 11'd1024 (mid-scale).
  - IDLE, PREFILL and DONE: no pops.
- **Pushes after finish:** still accepted in DRAIN; ignored in DONE (sample_ack never rises).
- **PWM:**
  - An 11-bit free-running counter p runs 0..2047 and wraps.
  - pwm_out = (p < dac_sample), registered.
  - dac_sample = 0 gives constant 0; dac_sample = 2047 gives low for one of every 2048 cycles.

## Timing
- **Reset values:** sample_ack=0, pwm_out=0, dac_sample=11'd1024, underrun=0, done=0, state=IDLE, count=0, pointers=0, tick counter=0, p=0.
- **Reset mid-operation:** FIFO contents are discarded; all outputs return to their reset values immediately (asynchronous).
- **Push latency:**
  - sample_valid rising before edge k → vs high after edge k+1 → push and sample_ack high after edge k+2.
  - sample_ack falls two edges after sample_valid falls.
- **Pop:** dac_sample updates on the edge that samples tick=1. pwm_out reflects the new value one cycle later.
- **Flag timing:** done rises on the edge that enters DONE. underrun rises on the same edge as the failed pop.
- **Full FIFO plus tick:** a pop and a waiting push in the same cycle both complete.

## Test plan
- **Reset:** rst=0 mid-PLAY → sample_ack=0, dac_sample=1024, underrun=0, done=0, count=0 on the same cycle.
- **Prefill:**
  - Setup: SAMPLE_DIV=8, PREFILL=4.
  - Stimulus: push 100,200,300,400 with a full 4-phase handshake each.
  - Required: no pop before the 4th push; next tick gives dac_sample=100; then 200 and 300 at 8-cycle intervals.
- **Full stall:**
  - Setup: DEPTH=4, PREFILL=4, SAMPLE_DIV large.
  - Stimulus: push 5 samples.
  - Required: 5th sample_ack stays low until the first tick pop, rises 1 cycle later; dac_sample sequence preserves order.
- **Underrun:**
  - Setup: PLAY with 1 entry, no further pushes.
  - Required: second tick leaves dac_sample held and sets underrun=1; underrun stays 1 after later pushes.
- **Drain/done:**
  - Stimulus: assert finish with 3 entries queued.
  - Required: 3 more pops, then on the next tick done=1, dac_sample=1024, underrun unchanged; a later sample_valid gets no ack.
- **PWM duty:** dac_sample=512 → pwm_out high for exactly 512 of 2048 cycles; dac_sample=0 → pwm_out constant 0.
